// File: rtl/swipe_tracker_if.sv
// Bundle of centroid input, history read port and tracker outputs for swipe_tracker.
// master: the producer/consumer around the tracker; slave: the tracker itself.
interface swipe_tracker_if #(
    parameter int HIST_DEPTH = 8
) ();
    localparam int IDX_W = $clog2(HIST_DEPTH);

    logic [10:0]       x_in;
    logic [9:0]        y_in;
    logic              valid_in;
    logic              frame_in;
    logic [IDX_W-1:0]  hist_idx_in;

    logic [10:0]        x_out;
    logic [9:0]         y_out;
    logic signed [11:0] dx_out;
    logic signed [10:0] dy_out;
    logic [11:0]        speed_out;
    logic               tracking_out;
    logic               swipe_out;
    logic               swipe_start_out;
    logic [10:0]        hist_x_out;
    logic [9:0]         hist_y_out;
    logic               hist_valid_out;

    modport master (
        output x_in, y_in, valid_in, frame_in, hist_idx_in,
        input  x_out, y_out, dx_out, dy_out, speed_out, tracking_out,
               swipe_out, swipe_start_out, hist_x_out, hist_y_out, hist_valid_out
    );

    modport slave (
        input  x_in, y_in, valid_in, frame_in, hist_idx_in,
        output x_out, y_out, dx_out, dy_out, speed_out, tracking_out,
               swipe_out, swipe_start_out, hist_x_out, hist_y_out, hist_valid_out
    );
endinterface

// File: rtl/swipe_tracker.sv
// Blade tracker: consumes one centroid per frame, keeps a ring history for the
// trail, computes per-frame velocity and classifies idle/acquire/track/swipe.
// Optional build macro SWIPE_SMOOTH_EN: x/y_out become a 1/2-weight EMA of the
// raw points; velocity, history and state always use raw points.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no track; history empty
// ACQUIRE  | first point of a new track captured, no velocity yet
// TRACKING | track alive, last step below SPEED_THRESH
// SWIPING  | track alive, last step at or above SPEED_THRESH
module swipe_tracker #(
    parameter int HIST_DEPTH   = 8,
    parameter int SPEED_THRESH = 40,
    parameter int LOST_FRAMES  = 4
) (
    input logic            clk_in,
    input logic            rst_in,
    swipe_tracker_if.slave bus
);
    localparam int PTR_W  = $clog2(HIST_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int MISS_W = $clog2(LOST_FRAMES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACQUIRE, S_TRACKING, S_SWIPING} state_t;

    state_t state, state_nxt;

    logic [10:0]        mem_x [HIST_DEPTH];
    logic [9:0]         mem_y [HIST_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_addr;
    logic [CNT_W-1:0]   hist_cnt;
    logic [MISS_W-1:0]  miss_cnt;
    logic               win_flag;
    logic [10:0]        prev_x;
    logic [9:0]         prev_y;

    logic signed [11:0] dx_calc;
    logic signed [10:0] dy_calc;
    logic [11:0]        abs_dx;
    logic [10:0]        abs_dy;
    logic [11:0]        speed_calc;
    logic               frame_hit;
    logic               track_lost;
    logic               swipe_start_nxt;

    assign dx_calc    = $signed({1'b0, bus.x_in}) - $signed({1'b0, prev_x});
    assign dy_calc    = $signed({1'b0, bus.y_in}) - $signed({1'b0, prev_y});
    assign abs_dx     = dx_calc[11] ? -dx_calc : dx_calc;
    assign abs_dy     = dy_calc[10] ? -dy_calc : dy_calc;
    assign speed_calc = abs_dx + {1'b0, abs_dy};

    // A point arriving on the closing strobe still belongs to the window being closed.
    assign frame_hit  = win_flag | bus.valid_in;
    assign track_lost = bus.frame_in && !frame_hit && (state != S_IDLE) &&
                        (miss_cnt == MISS_W'(LOST_FRAMES - 1));

    // Newest entry sits one behind the write pointer; the subtraction wraps the ring.
    assign rd_addr = wr_ptr - PTR_W'(1) - bus.hist_idx_in;

`ifdef SWIPE_SMOOTH_EN
    logic signed [11:0] ema_dx;
    logic signed [10:0] ema_dy;
    logic [10:0]        ema_x;
    logic [9:0]         ema_y;

    assign ema_dx = $signed({1'b0, bus.x_in}) - $signed({1'b0, bus.x_out});
    assign ema_dy = $signed({1'b0, bus.y_in}) - $signed({1'b0, bus.y_out});
    assign ema_x  = 11'($signed({1'b0, bus.x_out}) + (ema_dx >>> 1));
    assign ema_y  = 10'($signed({1'b0, bus.y_out}) + (ema_dy >>> 1));
`endif

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and swipe-entry pulse.
    always_comb begin
        state_nxt       = state;
        swipe_start_nxt = 1'b0;
        if (track_lost) begin
            state_nxt = S_IDLE;
        end else if (bus.valid_in) begin
            if (state == S_IDLE) begin
                state_nxt = S_ACQUIRE;
            end else if (speed_calc >= 12'(SPEED_THRESH)) begin
                state_nxt       = S_SWIPING;
                swipe_start_nxt = (state != S_SWIPING);
            end else begin
                state_nxt = S_TRACKING;
            end
        end
    end

    // Ring storage; contents need no reset because reads are gated by hist_cnt.
    always_ff @(posedge clk_in) begin
        if (!rst_in && bus.valid_in) begin
            mem_x[wr_ptr] <= bus.x_in;
            mem_y[wr_ptr] <= bus.y_in;
        end
    end

    // Track datapath, frame-window miss counting and registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr              <= '0;
            hist_cnt            <= '0;
            miss_cnt            <= '0;
            win_flag            <= 1'b0;
            prev_x              <= '0;
            prev_y              <= '0;
            bus.x_out           <= '0;
            bus.y_out           <= '0;
            bus.dx_out          <= '0;
            bus.dy_out          <= '0;
            bus.speed_out       <= '0;
            bus.tracking_out    <= 1'b0;
            bus.swipe_out       <= 1'b0;
            bus.swipe_start_out <= 1'b0;
            bus.hist_x_out      <= '0;
            bus.hist_y_out      <= '0;
            bus.hist_valid_out  <= 1'b0;
        end else begin
            bus.swipe_start_out <= swipe_start_nxt;
            bus.tracking_out    <= (state_nxt == S_TRACKING) || (state_nxt == S_SWIPING);
            bus.swipe_out       <= (state_nxt == S_SWIPING);

            if (bus.frame_in) begin
                win_flag <= 1'b0;
                if (frame_hit || track_lost) miss_cnt <= '0;
                else if (state != S_IDLE)    miss_cnt <= miss_cnt + MISS_W'(1);
            end else if (bus.valid_in) begin
                win_flag <= 1'b1;
            end

            if (track_lost) begin
                hist_cnt      <= '0;
                bus.dx_out    <= '0;
                bus.dy_out    <= '0;
                bus.speed_out <= '0;
            end else if (bus.valid_in) begin
                prev_x <= bus.x_in;
                prev_y <= bus.y_in;
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (state == S_IDLE) begin
                    hist_cnt      <= CNT_W'(1);
                    bus.dx_out    <= '0;
                    bus.dy_out    <= '0;
                    bus.speed_out <= '0;
                end else begin
                    bus.dx_out    <= dx_calc;
                    bus.dy_out    <= dy_calc;
                    bus.speed_out <= speed_calc;
                    if (hist_cnt != CNT_W'(HIST_DEPTH)) hist_cnt <= hist_cnt + CNT_W'(1);
                end
`ifdef SWIPE_SMOOTH_EN
                if (state == S_IDLE) begin
                    bus.x_out <= bus.x_in;
                    bus.y_out <= bus.y_in;
                end else begin
                    bus.x_out <= ema_x;
                    bus.y_out <= ema_y;
                end
`else
                bus.x_out <= bus.x_in;
                bus.y_out <= bus.y_in;
`endif
            end

            if ({1'b0, bus.hist_idx_in} < hist_cnt) begin
                bus.hist_valid_out <= 1'b1;
                bus.hist_x_out     <= mem_x[rd_addr];
                bus.hist_y_out     <= mem_y[rd_addr];
            end else begin
                bus.hist_valid_out <= 1'b0;
                bus.hist_x_out     <= '0;
                bus.hist_y_out     <= '0;
            end
        end
    end
endmodule

// File: tb/tb_swipe_tracker.sv
// Scoreboard bench for swipe_tracker: each stimulus step queues the expected
// registered outputs; a negedge monitor pops and compares them when due.
module tb_swipe_tracker;
    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    int   edge_cnt = 0;
    int   n_tests  = 0;
    int   n_fail   = 0;

`ifdef SWIPE_SMOOTH_EN
    localparam bit SMOOTH = 1'b1;
`else
    localparam bit SMOOTH = 1'b0;
`endif

    swipe_tracker_if bus ();

    swipe_tracker dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) edge_cnt++;

    typedef struct {
        string              name;
        int                 due;
        bit                 chk_xy;
        logic [10:0]        x;
        logic [9:0]         y;
        logic signed [11:0] dx;
        logic signed [10:0] dy;
        logic [11:0]        spd;
        logic               trk, swp, st, hv;
        logic [10:0]        hx;
        logic [9:0]         hy;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    bit   ok;

    logic [10:0]        e_x;
    logic [9:0]         e_y;
    logic signed [11:0] e_dx;
    logic signed [10:0] e_dy;
    logic [11:0]        e_spd;
    logic               e_trk, e_swp, e_st, e_hv;
    logic [10:0]        e_hx;
    logic [9:0]         e_hy;
    bit                 chk_xy = 1'b1;

    task automatic set_o(input int x, input int y, input int dx, input int dy, input int spd,
                         input bit trk, input bit swp, input bit st);
        e_x = 11'(x); e_y = 10'(y); e_dx = 12'(dx); e_dy = 11'(dy); e_spd = 12'(spd);
        e_trk = trk; e_swp = swp; e_st = st;
    endtask

    task automatic set_h(input bit hv, input int hx, input int hy);
        e_hv = hv; e_hx = 11'(hx); e_hy = 10'(hy);
    endtask

    // Drive one cycle of inputs, queue what the outputs must show after the edge.
    task automatic step(input string name, input bit v, input bit f, input int x, input int y,
                        input int idx);
        exp_t e;
        bus.valid_in    = v;
        bus.frame_in    = f;
        bus.x_in        = 11'(x);
        bus.y_in        = 10'(y);
        bus.hist_idx_in = 3'(idx);
        e.name = name; e.due = edge_cnt + 1; e.chk_xy = chk_xy;
        e.x = e_x; e.y = e_y; e.dx = e_dx; e.dy = e_dy; e.spd = e_spd;
        e.trk = e_trk; e.swp = e_swp; e.st = e_st; e.hv = e_hv; e.hx = e_hx; e.hy = e_hy;
        sb_q.push_back(e);
        e_st = 1'b0;
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset(input string name);
        rst_in = 1'b1;
        set_o(0, 0, 0, 0, 0, 0, 0, 0);
        set_h(0, 0, 0);
        step(name, 1, 1, 300, 100, 0);
        rst_in = 1'b0;
    endtask

    // Monitor: compare every queued expectation on the negedge it falls due.
    always @(negedge clk_in) begin
        while (sb_q.size() > 0 && sb_q[0].due <= edge_cnt) begin
            mon_e = sb_q.pop_front();
            n_tests++;
            ok = (mon_e.due == edge_cnt) &&
                 (!mon_e.chk_xy || (bus.x_out == mon_e.x && bus.y_out == mon_e.y)) &&
                 bus.dx_out == mon_e.dx && bus.dy_out == mon_e.dy &&
                 bus.speed_out == mon_e.spd && bus.tracking_out == mon_e.trk &&
                 bus.swipe_out == mon_e.swp && bus.swipe_start_out == mon_e.st &&
                 bus.hist_valid_out == mon_e.hv && bus.hist_x_out == mon_e.hx &&
                 bus.hist_y_out == mon_e.hy;
            if (!ok) begin
                n_fail++;
                $display("FAIL %s: got x=%0d y=%0d dx=%0d dy=%0d spd=%0d trk=%0d swp=%0d st=%0d hv=%0d hx=%0d hy=%0d | want x=%0d y=%0d dx=%0d dy=%0d spd=%0d trk=%0d swp=%0d st=%0d hv=%0d hx=%0d hy=%0d",
                         mon_e.name, bus.x_out, bus.y_out, bus.dx_out, bus.dy_out, bus.speed_out,
                         bus.tracking_out, bus.swipe_out, bus.swipe_start_out, bus.hist_valid_out,
                         bus.hist_x_out, bus.hist_y_out, mon_e.x, mon_e.y, mon_e.dx, mon_e.dy,
                         mon_e.spd, mon_e.trk, mon_e.swp, mon_e.st, mon_e.hv, mon_e.hx, mon_e.hy);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, queue=%0d required 0", sb_q.size());
        $fatal(1);
    end

    initial begin
        bus.valid_in = 1'b0; bus.frame_in = 1'b0;
        bus.x_in = '0; bus.y_in = '0; bus.hist_idx_in = '0;

        // reset, including strobes that must be ignored
        do_reset("reset_a");
        do_reset("reset_b");

        // acquisition
        set_o(100, 100, 0, 0, 0, 0, 0, 0); set_h(0, 0, 0);
        step("acquire_pt", 1, 0, 100, 100, 0);
        set_h(1, 100, 100);
        step("acquire_hist0", 0, 0, 0, 0, 0);
        set_h(0, 0, 0);
        step("hist_idx1_invalid", 0, 0, 0, 0, 1);

        // first swipe with entry pulse, then slow step
        set_o(SMOOTH ? 125 : 150, SMOOTH ? 110 : 120, 50, 20, 70, 1, 1, 1); set_h(1, 100, 100);
        step("swipe_pt", 1, 0, 150, 120, 0);
        if (SMOOTH) chk_xy = 1'b0;
        set_o(150, 120, 50, 20, 70, 1, 1, 0); set_h(1, 150, 120);
        step("swipe_hold", 0, 0, 0, 0, 0);
        set_o(160, 125, 10, 5, 15, 1, 0, 0); set_h(1, 150, 120);
        step("track_slow", 1, 0, 160, 125, 0);

        // signed deltas and threshold boundary
        set_o(500, 300, 340, 175, 515, 1, 1, 1); set_h(1, 160, 125);
        step("jump", 1, 0, 500, 300, 0);
        set_o(490, 310, -10, 10, 20, 1, 0, 0); set_h(1, 500, 300);
        step("neg_dx", 1, 0, 490, 310, 0);
        set_o(490, 350, 0, 40, 40, 1, 1, 1); set_h(1, 490, 310);
        step("thresh_equal", 1, 0, 490, 350, 0);
        set_o(490, 350, 0, 0, 0, 1, 0, 0); set_h(1, 490, 350);
        step("still", 1, 0, 490, 350, 0);
        set_o(540, 350, 50, 0, 50, 1, 1, 1); set_h(1, 490, 350);
        step("reswipe", 1, 0, 540, 350, 0);
        set_o(600, 350, 60, 0, 60, 1, 1, 0); set_h(1, 540, 350);
        step("swipe_no_repulse", 1, 0, 600, 350, 0);
        set_o(639, 350, 39, 0, 39, 1, 0, 0); set_h(1, 600, 350);
        step("thresh_below", 1, 0, 639, 350, 0);

        // ring fill past depth
        do_reset("reset_fill");
        set_o(0, 0, 0, 0, 0, 0, 0, 0); set_h(0, 0, 0);
        step("fill_0", 1, 0, 0, 0, 0);
        for (int k = 1; k < 10; k++) begin
            set_o(k, 0, 1, 0, 1, 1, 0, 0); set_h(1, k - 1, 0);
            step("fill_k", 1, 0, k, 0, 0);
        end
        set_h(1, 9, 0);
        step("hist_newest", 0, 0, 0, 0, 0);
        set_h(1, 2, 0);
        step("hist_oldest", 0, 0, 0, 0, 7);

        // miss counting and track loss
        set_h(1, 9, 0);
        step("frame_close", 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("miss_a", 0, 1, 0, 0, 0);
        set_o(20, 0, 11, 0, 11, 1, 0, 0); set_h(1, 9, 0);
        step("recover_pt", 1, 0, 20, 0, 0);
        set_h(1, 20, 0);
        step("frame_close2", 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("miss_b", 0, 1, 0, 0, 0);
        set_o(20, 0, 0, 0, 0, 0, 0, 0); set_h(1, 20, 0);
        step("track_lost", 0, 1, 0, 0, 0);
        set_h(0, 0, 0);
        step("lost_hist", 0, 0, 0, 0, 0);
        step("idle_frame", 0, 1, 0, 0, 0);
        set_o(30, 5, 0, 0, 0, 0, 0, 0); set_h(0, 0, 0);
        step("reacquire", 1, 0, 30, 5, 0);

        // point on the closing strobe counts for the closed window
        set_o(31, 5, 1, 0, 1, 1, 0, 0); set_h(1, 30, 5);
        step("valid_and_frame", 1, 1, 31, 5, 0);
        set_h(1, 31, 5);
        for (int i = 0; i < 3; i++) step("miss_c", 0, 1, 0, 0, 0);
        set_o(31, 5, 0, 0, 0, 0, 0, 0); set_h(1, 31, 5);
        step("lost_c", 0, 1, 0, 0, 0);
        set_h(0, 0, 0);
        step("lost_c_hist", 0, 0, 0, 0, 0);

        // reset in the middle of a swipe
        set_o(100, 100, 0, 0, 0, 0, 0, 0); set_h(0, 0, 0);
        step("acquire2", 1, 0, 100, 100, 0);
        set_o(200, 100, 100, 0, 100, 1, 1, 1); set_h(1, 100, 100);
        step("swipe2", 1, 0, 200, 100, 0);
        do_reset("reset_mid_swipe");
        step("post_reset", 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk_in);
        #1;
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: pending=%0d required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
